// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Compile with MUX_ARB_TIMEOUT_EN to size and enable the hold counter.
package mux_arb_pkg;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // Counter width able to hold 0 .. max_hold-1.
   function automatic int hold_w(input int max_hold);
      if (max_hold <= 2) begin
         return 1;
      end else begin
         return $clog2(max_hold);
      end
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first unmasked request scanning from ptr upward (mod 4).
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] mask,
   input  logic [SEL_W-1:0] ptr,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   logic [N_REQ-1:0]   eff_s;
   logic [2*N_REQ-1:0] dbl_s;
   logic [N_REQ-1:0]   rot_s;
   logic [SEL_W-1:0]   off_s;

   // Rotate eligible requests so ptr lands at bit 0, then take the lowest set bit.
   always_comb begin
      eff_s = req & ~mask;
      dbl_s = {eff_s, eff_s} >> ptr;
      rot_s = dbl_s[N_REQ-1:0];
      casez (rot_s)
         4'b???1: off_s = 2'd0;
         4'b??10: off_s = 2'd1;
         4'b?100: off_s = 2'd2;
         4'b1000: off_s = 2'd3;
         default: off_s = 2'd0;
      endcase
      found = |eff_s;
      idx   = ptr + off_s;
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner controller for a shared 4:1 data mux; grants are held until release.
// Optional MUX_ARB_TIMEOUT_EN forces rotation after MAX_HOLD busy cycles when others wait.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DATA_W   = 1,
   parameter int MAX_HOLD = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] din,
   output logic [N_REQ-1:0]        gnt,
   output logic [SEL_W-1:0]        sel,
   output logic                    valid,
   output logic [DATA_W-1:0]       dout
);

   if (MAX_HOLD < 2) begin : g_hold_chk
      $error("MAX_HOLD must be at least 2");
   end

   state_e           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             valid_q, valid_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;

   logic [N_REQ-1:0] mask_s;
   logic             found_s;
   logic [SEL_W-1:0] idx_s;
   logic             grant_s;
   logic             drop_s;

`ifdef MUX_ARB_TIMEOUT_EN
   localparam int HOLD_W = hold_w(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   logic [HOLD_W-1:0] hold_q, hold_d;
`endif

   // The owner is masked so a forced rotation never re-picks it; on release its req is low anyway.
   always_comb begin
      if (valid_q) begin
         mask_s = onehot(sel_q);
      end else begin
         mask_s = {N_REQ{1'b0}};
      end
   end

   rr_pick u_pick (
      .req   (req),
      .mask  (mask_s),
      .ptr   (ptr_q),
      .found (found_s),
      .idx   (idx_s)
   );

   // Next-state: decide whether to take a new grant, drop to idle, or hold.
   always_comb begin
      grant_s = 1'b0;
      drop_s  = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_d  = hold_q;
`endif
      case (state_q)
         IDLE: begin
            if (found_s) begin
               grant_s = 1'b1;
            end else begin
               drop_s = 1'b1;
            end
         end
         BUSY: begin
            if (!req[sel_q]) begin
               if (found_s) begin
                  grant_s = 1'b1;
               end else begin
                  drop_s = 1'b1;
               end
            end else begin
`ifdef MUX_ARB_TIMEOUT_EN
               if ((hold_q == HOLD_LAST) && found_s) begin
                  grant_s = 1'b1;
               end else if (hold_q != HOLD_LAST) begin
                  hold_d = hold_q + {{(HOLD_W-1){1'b0}}, 1'b1};
               end else begin
                  hold_d = hold_q;
               end
`else
               grant_s = 1'b0;
`endif
            end
         end
         default: begin
            drop_s = 1'b1;
         end
      endcase

      if (grant_s) begin
         state_d = BUSY;
         gnt_d   = onehot(idx_s);
         sel_d   = idx_s;
         valid_d = 1'b1;
         ptr_d   = idx_s + 2'd1;
`ifdef MUX_ARB_TIMEOUT_EN
         hold_d  = {HOLD_W{1'b0}};
`endif
      end else if (drop_s) begin
         state_d = IDLE;
         gnt_d   = {N_REQ{1'b0}};
         sel_d   = sel_q;
         valid_d = 1'b0;
         ptr_d   = ptr_q;
      end else begin
         state_d = state_q;
         gnt_d   = gnt_q;
         sel_d   = sel_q;
         valid_d = valid_q;
         ptr_d   = ptr_q;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= {N_REQ{1'b0}};
         sel_q   <= {SEL_W{1'b0}};
         valid_q <= 1'b0;
         ptr_q   <= {SEL_W{1'b0}};
`ifdef MUX_ARB_TIMEOUT_EN
         hold_q  <= {HOLD_W{1'b0}};
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
`ifdef MUX_ARB_TIMEOUT_EN
         hold_q  <= hold_d;
`endif
      end
   end

   // Data path is unregistered: the owner's word flows straight through while valid.
   always_comb begin
      if (valid_q) begin
         dout = din[int'(sel_q)*DATA_W +: DATA_W];
      end else begin
         dout = {DATA_W{1'b0}};
      end
   end

   assign gnt   = gnt_q;
   assign sel   = sel_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized plus directed bench for mux_rr_arbiter against a behavioural ownership model.
module tb_mux_rr_arbiter;

   localparam int DW = 8;
   localparam int MH = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      req;
   logic [4*DW-1:0] din;
   logic [3:0]      gnt;
   logic [1:0]      sel;
   logic            valid;
   logic [DW-1:0]   dout;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: owner index (-1 = nobody), rotation start, last select, hold length.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_sel   = 0;
   int m_hold  = 0;

   mux_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .din   (din),
      .gnt   (gnt),
      .sel   (sel),
      .valid (valid),
      .dout  (dout)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int start, input int excl);
      for (int k = 0; k < 4; k++) begin
         int j;
         j = (start + k) % 4;
         if (r[j] && j != excl) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_sel   = 0;
      m_hold  = 0;
   endtask

   task automatic model_grant(input int w);
      m_owner = w;
      m_sel   = w;
      m_ptr   = (w + 1) % 4;
      m_hold  = 0;
   endtask

   task automatic model_step(input logic [3:0] r);
      int w;
      if (m_owner < 0) begin
         w = pick(r, m_ptr, -1);
         if (w >= 0) model_grant(w);
      end else if (!r[m_owner]) begin
         w = pick(r, m_ptr, m_owner);
         if (w >= 0) model_grant(w);
         else m_owner = -1;
      end else begin
`ifdef MUX_ARB_TIMEOUT_EN
         w = pick(r, m_ptr, m_owner);
         if (m_hold == MH - 1) begin
            if (w >= 0) model_grant(w);
         end else begin
            m_hold++;
         end
`endif
      end
   endtask

   task automatic check_model(input string tag);
      logic [3:0]    eg;
      logic [DW-1:0] ed;
      eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      ed = (m_owner < 0) ? '0 : din[m_sel*DW +: DW];
      check_eq({tag, "_gnt"},   32'(gnt),   32'(eg));
      check_eq({tag, "_sel"},   32'(sel),   32'(m_sel));
      check_eq({tag, "_valid"}, 32'(valid), 32'(m_owner >= 0));
      check_eq({tag, "_dout"},  32'(dout),  32'(ed));
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step(req);
      #1;
      check_model(tag);
   endtask

   // Pulse async reset between edges and confirm outputs clear before any clock.
   task automatic mid_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      check_eq({tag, "_gnt"},   32'(gnt),   32'h0);
      check_eq({tag, "_sel"},   32'(sel),   32'h0);
      check_eq({tag, "_valid"}, 32'(valid), 32'h0);
      check_eq({tag, "_dout"},  32'(dout),  32'h0);
      model_reset();
      #1 rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] flip;
      rst = 1'b1;
      req = 4'b0000;
      din = '0;
      #1;
      check_model("reset");
      #12 rst = 1'b0;

      // Single request and release
      din = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
      req = 4'b0100;
      cycle("single");
      check_eq("single_gnt", 32'(gnt), 32'h4);
      check_eq("single_sel", 32'(sel), 32'h2);
      check_eq("single_dout", 32'(dout), 32'hCC);
      req = 4'b0000;
      cycle("release");
      check_eq("release_valid", 32'(valid), 32'h0);
      check_eq("release_sel", 32'(sel), 32'h2);

      // Async reset while requester 2 owns the mux
      req = 4'b0100;
      cycle("pre_rst");
      req = 4'b0000;
      mid_reset("mid_rst");
      cycle("post_rst");

      // Zero-bubble handoff 1 -> 3
      req = 4'b1010;
      cycle("hand_a");
      check_eq("hand_a_gnt", 32'(gnt), 32'h2);
      req = 4'b1000;
      cycle("hand_b");
      check_eq("hand_b_gnt", 32'(gnt), 32'h8);
      check_eq("hand_b_valid", 32'(valid), 32'h1);
      req = 4'b0000;
      cycle("hand_idle");

      // Fairness: all requesting, current owner drops for one cycle each time
      req = 4'b1111;
      cycle("fair0");
      check_eq("fair_sel0", 32'(sel), 32'h0);
      for (int i = 1; i <= 4; i++) begin
         req = 4'b1111 & ~gnt;
         cycle("fair");
         check_eq("fair_seq", 32'(sel), 32'(i % 4));
         check_eq("fair_nobubble", 32'(valid), 32'h1);
      end
      req = 4'b0000;
      cycle("fair_idle");

      // Data steering follows din combinationally
      req = 4'b1000;
      cycle("steer");
      check_eq("steer_dout", 32'(dout), 32'hDD);
      din[31:24] = 8'h11;
      #1;
      check_eq("steer_live", 32'(dout), 32'h11);
      check_model("steer_live");
      req = 4'b0000;
      cycle("steer_idle");

      // Owner 0 holds with requester 1 waiting
      req = 4'b0001;
      cycle("hold0");
      req = 4'b0011;
`ifdef MUX_ARB_TIMEOUT_EN
      for (int i = 0; i < MH - 1; i++) begin
         cycle("hold");
         check_eq("hold_gnt", 32'(gnt), 32'h1);
      end
      cycle("timeout");
      check_eq("timeout_gnt", 32'(gnt), 32'h2);
`else
      for (int i = 0; i < 12; i++) begin
         cycle("hold");
         check_eq("hold_gnt", 32'(gnt), 32'h1);
      end
`endif
      req = 4'b0000;
      cycle("hold_idle");

      // Random traffic: sticky requests with occasional flips, random data, rare resets
      for (int n = 0; n < 600; n++) begin
         flip = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         req  = req ^ flip;
         din  = $urandom;
         if ($urandom_range(0, 99) == 0) begin
            mid_reset("rand_rst");
         end
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
